// File: rtl/maxnet_engine.sv
// -----------------------------------------------------------------------------
// maxnet_engine
//
// Self-sequenced winner-take-all (Maxnet) core. The block loads N signed
// fixed-point scores over a valid/ready stream and then repeats the
// lateral-inhibition update until one of three things happens:
//   - exactly one activation is non-zero,
//   - all activations are zero, or
//   - the iteration limit is reached.
// It then presents the winner index and that neuron's raw loaded score
// through a second valid/ready handshake.
//
// Parameters
//   N         neuron count (>= 2)
//   W         data width, signed two's complement Q(W-F).F
//   F         fractional bits
//   EPS       inhibition weight in the same Q format, < 1/(N-1)
//   MAX_ITER  update iteration limit (1..255)
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    score stream; beat k loads neuron k
//   in_data  [W]         score for the current neuron
//   out_valid/out_ready  result handshake
//   win_idx  [clog2 N]   winning neuron index
//   win_val  [W]         raw loaded score of win_idx
//   iter_cnt [8]         number of update iterations performed
//   no_winner            every activation reached zero
//   timeout              MAX_ITER reached with more than one survivor
//   busy                 iterating (EVAL or UPDATE)
// -----------------------------------------------------------------------------
module maxnet_engine #(
  parameter int                  N        = 4,
  parameter int                  W        = 32,
  parameter int                  F        = 16,
  parameter logic signed [W-1:0] EPS      = 32'sh0000_2000,
  parameter int                  MAX_ITER = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] win_idx,
  output logic [W-1:0]         win_val,
  output logic [7:0]           iter_cnt,
  output logic                 no_winner,
  output logic                 timeout,
  output logic                 busy
);

  localparam int LN = $clog2(N);
  localparam int SW = W + LN;   // activation sum width, cannot overflow
  localparam int DW = SW + 1;   // signed (S - a[i])
  localparam int PW = W + DW;   // full-width product EPS * (S - a[i])

  // Largest value an activation may hold: 2^(W-1) - 1.
  localparam logic signed [PW:0] A_MAX = {{(PW-W+2){1'b0}}, {(W-1){1'b1}}};

  typedef enum logic [1:0] {LOAD, EVAL, UPDATE, DONE} state_t;

  state_t          state_q, state_d;
  logic [LN-1:0]   load_idx;
  logic [W-1:0]    x [N];        // raw loaded scores
  logic [W-1:0]    a [N];        // activations, always in [0, 2^(W-1)-1]
  logic [SW-1:0]   sum_q;
  logic [SW-1:0]   sum_c;
  logic [LN-1:0]   low_idx;      // lowest non-zero activation index
  logic            found;        // at least one activation non-zero
  logic            multi;        // more than one activation non-zero
  logic            at_limit;

  // One lateral-inhibition step for a single neuron:
  //   clamp(a - ((EPS * (S - a)) >>> F)) into [0, 2^(W-1)-1]
  function automatic logic [W-1:0] inhibit(input logic [W-1:0]  ai,
                                            input logic [SW-1:0] s);
    logic signed [DW-1:0] diff;
    logic signed [PW-1:0] prod;
    logic signed [PW:0]   v;
    diff = $signed({1'b0, s}) - $signed({{(LN+1){1'b0}}, ai});
    prod = PW'(EPS) * PW'(diff);
    v    = $signed({{(PW-W+1){1'b0}}, ai}) - (PW+1)'(prod >>> F);
    if (v < 0)
      return '0;
    else if (v > A_MAX)
      return {1'b0, {(W-1){1'b1}}};
    else
      return v[W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Survivor scan and activation sum
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip an assignment infer latches.
    sum_c   = '0;
    low_idx = '0;
    found   = 1'b0;
    multi   = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_c = sum_c + SW'(a[i]);
      if (a[i] != '0) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found   = 1'b1;
          low_idx = LN'(i);
        end
      end
    end
  end

  // The limit is checked against the count before increment, so exactly
  // MAX_ITER updates run before a timeout is declared.
  assign at_limit = (iter_cnt == 8'(MAX_ITER));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (in_valid && load_idx == LN'(N-1)) state_d = EVAL;
      EVAL:    state_d = (!multi || at_limit) ? DONE : UPDATE;
      UPDATE:  state_d = EVAL;
      DONE:    if (out_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == EVAL) || (state_q == UPDATE);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the score and activation arrays are small register files with a
      // defined reset value, so they are cleared here rather than left
      // uninitialised like an inferred RAM would be.
      for (int i = 0; i < N; i++) begin
        x[i] <= '0;
        a[i] <= '0;
      end
      load_idx  <= '0;
      sum_q     <= '0;
      iter_cnt  <= '0;
      win_idx   <= '0;
      win_val   <= '0;
      no_winner <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (in_valid) begin
            x[load_idx] <= in_data;
            a[load_idx] <= in_data[W-1] ? '0 : in_data;
            if (load_idx == '0) iter_cnt <= '0;
            load_idx <= (load_idx == LN'(N-1)) ? '0 : load_idx + LN'(1);
          end
        end
        EVAL: begin
          if (!multi) begin
            // Single survivor, or none (low_idx stays 0 when nothing is set).
            win_idx   <= low_idx;
            win_val   <= x[low_idx];
            no_winner <= !found;
          end else if (at_limit) begin
            win_idx <= low_idx;
            win_val <= x[low_idx];
            timeout <= 1'b1;
          end else begin
            sum_q <= sum_c;
          end
        end
        UPDATE: begin
          for (int i = 0; i < N; i++) a[i] <= inhibit(a[i], sum_q);
          iter_cnt <= iter_cnt + 8'd1;
        end
        DONE: begin
          if (out_ready) begin
            no_winner <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_engine.sv
// -----------------------------------------------------------------------------
// tb_maxnet_engine
//
// Self-checking bench for maxnet_engine (N=4, W=32, F=16, EPS=0.125,
// MAX_ITER=8). Directed vectors come from a table of hand-derived results,
// multi-cycle corner cases are hand-written sequences, and randomized vectors
// are compared against a behavioural Maxnet model using 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_maxnet_engine;

  localparam int     N        = 4;
  localparam int     W        = 32;
  localparam int     F        = 16;
  localparam int     MAX_ITER = 8;
  localparam longint EPS_L    = 64'sd8192;   // 0.125 in Q16.16

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   win_idx;
  logic [W-1:0] win_val;
  logic [7:0]   iter_cnt;
  logic         no_winner;
  logic         timeout;
  logic         busy;

  maxnet_engine #(
    .N(N), .W(W), .F(F), .EPS(32'sh0000_2000), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .win_idx  (win_idx),
    .win_val  (win_val),
    .iter_cnt (iter_cnt),
    .no_winner(no_winner),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef logic [N-1:0][W-1:0] vec_t;

  typedef struct {
    logic [1:0]   idx;
    logic [W-1:0] val;
    int           iter;
    logic         nw;
    logic         to;
  } res_t;

  typedef struct {
    string name;
    vec_t  d;
    res_t  exp;
  } tcase_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  tcase_t tbl[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [W-1:0] d2, input logic [W-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic add(input string name, input vec_t d, input logic [1:0] idx,
                     input logic [W-1:0] val, input int iter, input logic nw,
                     input logic to);
    tcase_t t;
    t.name     = name;
    t.d        = d;
    t.exp.idx  = idx;
    t.exp.val  = val;
    t.exp.iter = iter;
    t.exp.nw   = nw;
    t.exp.to   = to;
    tbl.push_back(t);
  endtask

  // Behavioural Maxnet: iterate the inhibition rule on plain integers.
  function automatic res_t model(input vec_t d);
    longint act [N];
    longint nxt [N];
    longint s;
    int     nz;
    int     low;
    bit     fin;
    res_t   r;
    r.idx = '0; r.val = '0; r.iter = 0; r.nw = 1'b0; r.to = 1'b0;
    for (int i = 0; i < N; i++) begin
      act[i] = longint'($signed(d[i]));
      if (act[i] < 0) act[i] = 0;
    end
    fin = 1'b0;
    while (!fin) begin
      nz  = 0;
      low = -1;
      for (int i = 0; i < N; i++)
        if (act[i] != 0) begin
          nz++;
          if (low < 0) low = i;
        end
      if (nz == 1) begin
        r.idx = 2'(low); fin = 1'b1;
      end else if (nz == 0) begin
        r.idx = 2'd0; r.nw = 1'b1; fin = 1'b1;
      end else if (r.iter == MAX_ITER) begin
        r.idx = 2'(low); r.to = 1'b1; fin = 1'b1;
      end else begin
        s = 0;
        for (int i = 0; i < N; i++) s += act[i];
        for (int i = 0; i < N; i++) begin
          // Product is non-negative here, so division is the floor shift.
          nxt[i] = act[i] - (EPS_L * (s - act[i])) / (64'sd1 << F);
          if (nxt[i] < 0)                 nxt[i] = 0;
          if (nxt[i] > 64'sh7FFF_FFFF)    nxt[i] = 64'sh7FFF_FFFF;
        end
        for (int i = 0; i < N; i++) act[i] = nxt[i];
        r.iter++;
      end
    end
    r.val = d[r.idx];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_score();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return 32'($urandom_range(1, 32'h0004_0000));
      2:       return 32'h8000_0000 | 32'($urandom);
      3:       return {1'b0, 31'($urandom)};
      default: return 32'h0001_0000 + 32'($urandom_range(0, 256));
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {in_ready, out_valid, busy, no_winner, timeout}, 5'b10000);
    check({tag, "_idx"}, win_idx, 0);
    check({tag, "_val"}, win_val, 0);
    check({tag, "_iter"}, iter_cnt, 0);
  endtask

  // Drive N beats, optionally separated by idle cycles carrying junk data.
  task automatic load_vec(input vec_t d, input int gap);
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Full transaction: load, measure latency, check result, optionally hold
  // the result under backpressure, then complete the output handshake.
  task automatic run_vec(input string tag, input vec_t d, input int gap,
                         input int hold, input res_t exp);
    int lat;
    int bad;
    out_ready = (hold == 0);
    load_vec(d, gap);
    check({tag, "_eval"}, {busy, in_ready, out_valid}, 3'b100);
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 1 + 2 * exp.iter);
    check({tag, "_idx"}, win_idx, exp.idx);
    check({tag, "_val"}, win_val, exp.val);
    check({tag, "_iter"}, iter_cnt, exp.iter[7:0]);
    check({tag, "_flags"}, {no_winner, timeout}, {exp.nw, exp.to});
    if (hold > 0) begin
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        @(posedge clk); #1;
        if (!out_valid || in_ready || win_idx !== exp.idx ||
            win_val !== exp.val || iter_cnt !== exp.iter[7:0] ||
            no_winner !== exp.nw || timeout !== exp.to)
          bad++;
      end
      in_valid = 1'b0;
      check({tag, "_hold"}, bad, 0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_xfer"}, {in_ready, out_valid, busy, no_winner, timeout}, 5'b10000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    vec_t d;

    add("one_hot",  mk(32'h0, 32'h0, 32'h0005_0000, 32'h0),
        2'd2, 32'h0005_0000, 0, 1'b0, 1'b0);
    // a0: 65536->49152->33792->19200->5136->0; a1 survives after 5 updates
    add("two_way",  mk(32'h0001_0000, 32'h0002_0000, 32'h0, 32'h0),
        2'd1, 32'h0002_0000, 5, 1'b0, 1'b0);
    add("all_eq",   mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000),
        2'd0, 32'h0001_0000, 8, 1'b0, 1'b1);
    add("neg_clamp", mk(32'hFFFD_0000, 32'h0, 32'h0, 32'h0004_0000),
        2'd3, 32'h0004_0000, 0, 1'b0, 1'b0);
    add("all_zero", mk(32'h0, 32'h0, 32'h0, 32'h0),
        2'd0, 32'h0, 0, 1'b1, 1'b0);
    add("all_neg",  mk(32'hFFFF_0000, 32'hFFFE_0000, 32'h0, 32'h0),
        2'd0, 32'hFFFF_0000, 0, 1'b1, 1'b0);
    add("max_pos",  mk(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0),
        2'd0, 32'h7FFF_FFFF, 0, 1'b0, 1'b0);

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i]) run_vec(tbl[i].name, tbl[i].d, 0, 0, tbl[i].exp);

    // Input gaps must give the same result as gap-free loading
    run_vec("gaps", tbl[1].d, 2, 0, tbl[1].exp);

    // Backpressure on a timeout result: flags must clear on the transfer
    run_vec("backpressure", tbl[2].d, 0, 10, tbl[2].exp);
    // Beats offered during DONE must have been ignored
    run_vec("after_bp", tbl[0].d, 0, 0, tbl[0].exp);

    // Reset in the middle of iterating: EVAL, UPDATE, EVAL(iter=1), UPDATE
    load_vec(tbl[2].d, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("mid_run_state", {busy, iter_cnt}, {1'b1, 8'd1});
    rst_n = 1'b0;
    #2;
    check_reset_vals("rst_update");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec("post_rst_update", tbl[0].d, 0, 0, tbl[0].exp);

    // Reset after three beats of a load: the partial vector is discarded
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h0005_0000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_vals("rst_partial");
    @(posedge clk); #1;
    rst_n = 1'b1;
    d = mk(32'h0, 32'h0007_0000, 32'h0, 32'h0);
    r.idx = 2'd1; r.val = 32'h0007_0000; r.iter = 0; r.nw = 1'b0; r.to = 1'b0;
    run_vec("post_rst_partial", d, 0, 0, r);

    // Randomized vectors against the behavioural model
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N; k++) d[k] = rnd_score();
      r = model(d);
      run_vec($sformatf("rand%0d", n), d, $urandom_range(0, 1),
              $urandom_range(0, 2), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
